// File: rtl/adc_sample_fifo.sv
// rtl/adc_sample_fifo.sv - decimating ADC sample FIFO with status, half-full irq and optional trigger
// Optional level trigger is built only when ADC_FIFO_TRIGGER_EN is defined.
module adc_sample_fifo #(
  parameter int DEPTH_LOG2 = 4,
  parameter int DATA_W     = 8
) (
  input  logic                  osc_clk,
  input  logic                  rst_n,
  input  logic [DATA_W-1:0]     i_sample,
  input  logic                  i_sample_valid,
  input  logic                  i_rd,
  input  logic                  i_stat_rd,
  input  logic                  i_ctrl_wr,
  input  logic                  i_trig_wr,
  input  logic [7:0]            i_wdata,
  output logic [DATA_W-1:0]     o_data,
  output logic [7:0]            o_status,
  output logic [DEPTH_LOG2:0]   o_level,
  output logic [7:0]            o_ctrl,
  output logic                  o_irq
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0]   FULL_LVL = (DEPTH_LOG2+1)'(DEPTH);
  localparam logic [DEPTH_LOG2:0]   HALF_LVL = (DEPTH_LOG2+1)'(DEPTH / 2);
  localparam logic [DEPTH_LOG2:0]   LVL_ONE  = (DEPTH_LOG2+1)'(1);
  localparam logic [DEPTH_LOG2-1:0] PTR_ONE  = DEPTH_LOG2'(1);

  logic [DATA_W-1:0]     mem_q [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [DEPTH_LOG2:0]   level_q, level_d;
  logic [DATA_W-1:0]     data_q, data_d;
  logic                  en_q, en_d, ovf_q, ovf_d, udf_q, udf_d;
  logic [3:0]            dec_q, dec_d, cnt_q, cnt_d;
  logic                  full, empty, flush, kept, offer;
  logic                  do_push, do_pop, ovf_evt, udf_evt;
  logic                  trig_armed, arm_rb;
  logic                  unused_inputs;

`ifdef ADC_FIFO_TRIGGER_EN
  logic              armed_q, armed_d, arm_bit_q, arm_bit_d, prev_below_q, prev_below_d;
  logic [DATA_W-1:0] trig_q, trig_d;
  logic              trig_hit;

  assign trig_hit   = armed_q && prev_below_q && (i_sample >= trig_q);
  assign offer      = kept && (!armed_q || trig_hit);
  assign trig_armed = armed_q;
  assign arm_rb     = arm_bit_q;

  always_comb begin
    armed_d      = armed_q;
    arm_bit_d    = arm_bit_q;
    prev_below_d = prev_below_q;
    trig_d       = trig_q;
    if (kept) prev_below_d = (i_sample < trig_q);
    if (trig_hit) armed_d = 1'b0;
    if (i_trig_wr) trig_d = DATA_W'(i_wdata);
    if (i_ctrl_wr) begin
      arm_bit_d = i_wdata[2];
      // Arming forgets history so an already-high level cannot fire immediately.
      if (i_wdata[2]) begin
        armed_d      = 1'b1;
        prev_below_d = 1'b0;
      end
    end
    if (flush) armed_d = 1'b0;
  end

  always_ff @(posedge osc_clk or negedge rst_n) begin
    if (!rst_n) begin
      armed_q      <= 1'b0;
      arm_bit_q    <= 1'b0;
      prev_below_q <= 1'b0;
      trig_q       <= DATA_W'(8'h80);
    end else begin
      armed_q      <= armed_d;
      arm_bit_q    <= arm_bit_d;
      prev_below_q <= prev_below_d;
      trig_q       <= trig_d;
    end
  end

  assign unused_inputs = i_wdata[3];
`else
  assign offer         = kept;
  assign trig_armed    = 1'b0;
  assign arm_rb        = 1'b0;
  assign unused_inputs = ^{i_wdata[3:2], i_trig_wr};
`endif

  assign full    = (level_q == FULL_LVL);
  assign empty   = (level_q == '0);
  assign flush   = i_ctrl_wr && i_wdata[1];
  assign kept    = i_sample_valid && en_q && (cnt_q == 4'd0);
  // Evaluated against pre-edge state: a pop frees the slot a same-cycle push needs.
  assign do_push = offer && (!full || i_rd);
  assign ovf_evt = offer && full && !i_rd;
  assign do_pop  = i_rd && !empty;
  assign udf_evt = i_rd && empty;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    data_d   = data_q;
    en_d     = en_q;
    dec_d    = dec_q;
    cnt_d    = cnt_q;
    ovf_d    = ovf_q;
    udf_d    = udf_q;
    if (i_sample_valid && en_q) cnt_d = (cnt_q == dec_q) ? 4'd0 : cnt_q + 4'd1;
    if (do_push) wr_ptr_d = wr_ptr_q + PTR_ONE;
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + PTR_ONE;
      data_d   = mem_q[rd_ptr_q];
    end else if (udf_evt) begin
      data_d = '0;
    end
    if (do_push && !do_pop) level_d = level_q + LVL_ONE;
    else if (do_pop && !do_push) level_d = level_q - LVL_ONE;
    if (ovf_evt) ovf_d = 1'b1;
    else if (i_stat_rd) ovf_d = 1'b0;
    if (udf_evt) udf_d = 1'b1;
    else if (i_stat_rd) udf_d = 1'b0;
    if (i_ctrl_wr) begin
      en_d  = i_wdata[0];
      dec_d = i_wdata[7:4];
    end
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      level_d  = '0;
      data_d   = data_q;
      ovf_d    = 1'b0;
      udf_d    = 1'b0;
      cnt_d    = 4'd0;
    end
  end

  always_ff @(posedge osc_clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      data_q   <= '0;
      en_q     <= 1'b0;
      dec_q    <= 4'd0;
      cnt_q    <= 4'd0;
      ovf_q    <= 1'b0;
      udf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
      data_q   <= data_d;
      en_q     <= en_d;
      dec_q    <= dec_d;
      cnt_q    <= cnt_d;
      ovf_q    <= ovf_d;
      udf_q    <= udf_d;
    end
  end

  // Buffer contents carry no reset; only pointers define validity.
  always_ff @(posedge osc_clk) begin
    if (do_push && !flush) mem_q[wr_ptr_q] <= i_sample;
  end

  assign o_data   = data_q;
  assign o_level  = level_q;
  assign o_irq    = en_q && (level_q >= HALF_LVL);
  assign o_ctrl   = {dec_q, 1'b0, arm_rb, 1'b0, en_q};
  assign o_status = {full, empty, ovf_q, udf_q, trig_armed, 1'b0, o_irq, en_q};

endmodule
